// File: rtl/spmv_pkg.sv
// Shared types and default constants for the SpMV tile scheduler.
package spmv_pkg;

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_ARM   = 3'd1,
        S_RUN   = 3'd2,
        S_DRAIN = 3'd3,
        S_NEXT  = 3'd4,
        S_DONE  = 3'd5,
        S_ERR   = 3'd6
    } state_t;

    localparam int DEF_IN_STRIDE  = 64;
    localparam int DEF_OUT_STRIDE = 1024;
    localparam int DEF_TIMEOUT    = 2048;
    localparam int DEF_ARM_CYCLES = 2;

    // Tile base address; only the low 16 bits of the product are kept.
    function automatic logic [15:0] base_of(input logic [7:0] idx, input int stride);
        logic [31:0] prod;
        prod = 32'(idx) * 32'(stride);
        return prod[15:0];
    endfunction

endpackage

// File: rtl/spmv_tile_sched_if.sv
// Job-control and engine handshake bundle between the host/engine side
// (master) and the tile scheduler (slave).
interface spmv_tile_sched_if;
    logic        start;
    logic        abort;
    logic [7:0]  num_tiles;
    logic        eng_dateout;
    logic        eng_idle;
    logic        busy;
    logic        done;
    logic        error;
    logic [7:0]  tile_idx;
    logic [15:0] in_base;
    logic [15:0] out_base;
    logic [31:0] job_cycles;

    modport master (
        output start, abort, num_tiles, eng_dateout,
        input  eng_idle, busy, done, error, tile_idx, in_base, out_base, job_cycles
    );

    modport slave (
        input  start, abort, num_tiles, eng_dateout,
        output eng_idle, busy, done, error, tile_idx, in_base, out_base, job_cycles
    );
endinterface

// File: rtl/spmv_watchdog.sv
// Per-tile watchdog: counts enabled cycles, flags expiry in the TIMEOUT-th
// enabled cycle since the last clear.
module spmv_watchdog
    import spmv_pkg::*;
#(
    parameter int TIMEOUT = DEF_TIMEOUT
) (
    input  logic clk,
    input  logic rst,
    input  logic clr_i,
    input  logic en_i,
    output logic expire_o
);

    localparam int CW = $clog2(TIMEOUT + 1);

    logic [CW-1:0] cnt_q, cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (clr_i) begin
            cnt_d = '0;
        end else if (en_i && (cnt_q != CW'(TIMEOUT))) begin
            cnt_d = cnt_q + CW'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    // cnt_q holds the number of enabled cycles already completed.
    assign expire_o = en_i && (cnt_q >= CW'(TIMEOUT - 1));

endmodule

// File: rtl/spmv_tile_sched.sv
// Tile scheduler for the SpMV engine: launches one tile per eng_idle falling
// edge, tracks tile bases, job cycle count and a per-tile timeout.
module spmv_tile_sched
    import spmv_pkg::*;
#(
    parameter int IN_STRIDE  = DEF_IN_STRIDE,
    parameter int OUT_STRIDE = DEF_OUT_STRIDE,
    parameter int TIMEOUT    = DEF_TIMEOUT,
    parameter int ARM_CYCLES = DEF_ARM_CYCLES
) (
    input  logic              clk,
    input  logic              rst,
    spmv_tile_sched_if.slave  bus
);

    state_t      state_q, state_d;
    logic [7:0]  num_q, num_d;
    logic [7:0]  tile_q, tile_d;
    logic [15:0] in_base_q, in_base_d;
    logic [15:0] out_base_q, out_base_d;
    logic [15:0] arm_q, arm_d;
    logic        busy_q, busy_d;
    logic        done_q, done_d;
    logic        error_q, error_d;
    logic [31:0] cyc_q, cyc_d;
    logic        hist_q;
    logic        rise, fall;
    logic        wd_en, wd_clr, wd_expire;

    assign rise   = bus.eng_dateout & ~hist_q;
    assign fall   = ~bus.eng_dateout & hist_q;
    assign wd_en  = (state_q == S_RUN) || (state_q == S_DRAIN);
    assign wd_clr = (state_q == S_ARM);

    spmv_watchdog #(.TIMEOUT(TIMEOUT)) u_watchdog (
        .clk      (clk),
        .rst      (rst),
        .clr_i    (wd_clr),
        .en_i     (wd_en),
        .expire_o (wd_expire)
    );

    always_comb begin
        state_d = state_q;
        num_d   = num_q;
        tile_d  = tile_q;
        arm_d   = arm_q;
        busy_d  = busy_q;
        done_d  = 1'b0;
        error_d = error_q;
        cyc_d   = cyc_q;
        if (busy_q && (cyc_q != '1)) begin
            cyc_d = cyc_q + 32'd1;
        end

        case (state_q)
            S_IDLE: begin
                if (bus.start) begin
                    num_d   = bus.num_tiles;
                    tile_d  = '0;
                    arm_d   = '0;
                    error_d = 1'b0;
                    cyc_d   = '0;
                    busy_d  = 1'b1;
                    state_d = (bus.num_tiles == 8'd0) ? S_DONE : S_ARM;
                end
            end
            S_ARM: begin
                if (arm_q == 16'(ARM_CYCLES - 1)) begin
                    state_d = S_RUN;
                end else begin
                    arm_d = arm_q + 16'd1;
                end
            end
            // An engine edge always beats a coincident watchdog expiry.
            S_RUN: begin
                if (rise) begin
                    state_d = S_DRAIN;
                end else if (wd_expire) begin
                    state_d = S_ERR;
                    error_d = 1'b1;
                end
            end
            S_DRAIN: begin
                if (fall) begin
                    state_d = S_NEXT;
                end else if (wd_expire) begin
                    state_d = S_ERR;
                    error_d = 1'b1;
                end
            end
            S_NEXT: begin
                if (({1'b0, tile_q} + 9'd1) == {1'b0, num_q}) begin
                    state_d = S_DONE;
                end else begin
                    tile_d  = tile_q + 8'd1;
                    arm_d   = '0;
                    state_d = S_ARM;
                end
            end
            S_DONE: begin
                state_d = S_IDLE;
                busy_d  = 1'b0;
                done_d  = 1'b1;
            end
            S_ERR: begin
                state_d = S_IDLE;
                busy_d  = 1'b0;
            end
            default: begin
                state_d = S_IDLE;
                busy_d  = 1'b0;
            end
        endcase

        if ((state_q != S_IDLE) && bus.abort) begin
            state_d = S_IDLE;
            busy_d  = 1'b0;
            done_d  = 1'b0;
            error_d = error_q;
            tile_d  = tile_q;
        end
    end

    assign in_base_d  = base_of(tile_d, IN_STRIDE);
    assign out_base_d = base_of(tile_d, OUT_STRIDE);

    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q    <= S_IDLE;
            num_q      <= '0;
            tile_q     <= '0;
            in_base_q  <= '0;
            out_base_q <= '0;
            arm_q      <= '0;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
            error_q    <= 1'b0;
            cyc_q      <= '0;
            hist_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            num_q      <= num_d;
            tile_q     <= tile_d;
            in_base_q  <= in_base_d;
            out_base_q <= out_base_d;
            arm_q      <= arm_d;
            busy_q     <= busy_d;
            done_q     <= done_d;
            error_q    <= error_d;
            cyc_q      <= cyc_d;
            hist_q     <= bus.eng_dateout;
        end
    end

    assign bus.eng_idle   = !((state_q == S_RUN) || (state_q == S_DRAIN));
    assign bus.busy       = busy_q;
    assign bus.done       = done_q;
    assign bus.error      = error_q;
    assign bus.tile_idx   = tile_q;
    assign bus.in_base    = in_base_q;
    assign bus.out_base   = out_base_q;
    assign bus.job_cycles = cyc_q;

endmodule

// File: tb/tb_spmv_tile_sched.sv
// Directed and randomized bench for spmv_tile_sched with a behavioural engine
// model and a per-job timing reference.
module tb_spmv_tile_sched;

    localparam int ARM     = 2;
    localparam int TMO     = 2048;
    localparam int IN_STR  = 64;
    localparam int OUT_STR = 1024;

    logic clk;
    logic rst;

    spmv_tile_sched_if bus ();

    spmv_tile_sched dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    int n_checks = 0;
    int n_pass   = 0;

    // Engine model: dateout high from cycle eng_delay after release for eng_len cycles.
    int rel        = 0;
    int eng_delay  = 10;
    int eng_len    = 10;
    bit eng_never  = 1'b0;

    initial begin
        bus.eng_dateout = 1'b0;
        forever begin
            @(negedge clk);
            if (bus.eng_idle !== 1'b0) rel = 0;
            else rel = rel + 1;
            bus.eng_dateout = !eng_never && (rel >= eng_delay) && (rel < eng_delay + eng_len);
        end
    end

    // Monitor of observable job events.
    int          cyc_n    = 0;
    int          falls    = 0;
    int          dones    = 0;
    int          fall_cyc = -1;
    int          err_cyc  = -1;
    logic        err_idle = 1'b0;
    logic        prev_idle = 1'b1;
    logic        prev_err  = 1'b0;
    logic [15:0] obq[$];

    initial begin
        forever begin
            @(negedge clk);
            cyc_n = cyc_n + 1;
            if ((prev_idle === 1'b1) && (bus.eng_idle === 1'b0)) begin
                falls = falls + 1;
                obq.push_back(bus.out_base);
                if (fall_cyc < 0) fall_cyc = cyc_n;
            end
            if (bus.done === 1'b1) dones = dones + 1;
            if ((bus.error === 1'b1) && (prev_err !== 1'b1) && (err_cyc < 0)) begin
                err_cyc  = cyc_n;
                err_idle = bus.eng_idle;
            end
            prev_idle = bus.eng_idle;
            prev_err  = bus.error;
        end
    end

    initial begin
        #1_000_000;
        $display("FAIL tb_timeout: simulation time limit reached");
        $fatal(1, "bench time limit");
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    endtask

    task automatic clear_mon();
        @(posedge clk);
        falls    = 0;
        dones    = 0;
        fall_cyc = -1;
        err_cyc  = -1;
        err_idle = 1'b0;
        obq.delete();
    endtask

    task automatic start_job(input int n);
        @(negedge clk);
        bus.num_tiles = 8'(n);
        bus.start     = 1'b1;
        @(negedge clk);
        bus.start     = 1'b0;
    endtask

    task automatic wait_idle(input int budget, input string tag);
        int k;
        k = 0;
        while ((bus.busy === 1'b1) && (k < budget)) begin
            @(negedge clk);
            k++;
        end
        check({tag, ".idle_in_budget"}, {31'd0, bus.busy}, 32'd0);
        @(negedge clk);
    endtask

    task automatic wait_tile_run(input logic [7:0] idx, input int budget, input string tag);
        int k;
        k = 0;
        while (!((bus.tile_idx === idx) && (bus.eng_idle === 1'b0)) && (k < budget)) begin
            @(negedge clk);
            k++;
        end
        check({tag, ".reached_tile"}, {24'd0, bus.tile_idx}, {24'd0, idx});
    endtask

    // Reference: each tile takes ARM + delay + len + 1 busy cycles, plus one DONE cycle.
    function automatic int job_len(input int n, input int d, input int l);
        return n * (ARM + d + l + 1) + 1;
    endfunction

    task automatic run_ok(input int n, input int d, input int l, input string tag);
        clear_mon();
        eng_never = 1'b0;
        eng_delay = d;
        eng_len   = l;
        start_job(n);
        wait_idle(job_len(n, d, l) + 20, tag);
        check({tag, ".falls"}, falls, n);
        check({tag, ".dones"}, dones, 1);
        check({tag, ".error"}, {31'd0, bus.error}, 32'd0);
        check({tag, ".job_cycles"}, bus.job_cycles, job_len(n, d, l));
        check({tag, ".tile_idx"}, {24'd0, bus.tile_idx}, n - 1);
        check({tag, ".in_base"}, {16'd0, bus.in_base}, ((n - 1) * IN_STR) % 65536);
        check({tag, ".out_base"}, {16'd0, bus.out_base}, ((n - 1) * OUT_STR) % 65536);
        check({tag, ".obq_size"}, obq.size(), n);
        for (int k = 0; k < obq.size(); k++) begin
            check({tag, ".tile_out_base"}, {16'd0, obq[k]}, (k * OUT_STR) % 65536);
        end
    endtask

    task automatic check_reset_vals(input string tag);
        check({tag, ".eng_idle"},   {31'd0, bus.eng_idle}, 32'd1);
        check({tag, ".busy"},       {31'd0, bus.busy},     32'd0);
        check({tag, ".done"},       {31'd0, bus.done},     32'd0);
        check({tag, ".error"},      {31'd0, bus.error},    32'd0);
        check({tag, ".tile_idx"},   {24'd0, bus.tile_idx}, 32'd0);
        check({tag, ".in_base"},    {16'd0, bus.in_base},  32'd0);
        check({tag, ".out_base"},   {16'd0, bus.out_base}, 32'd0);
        check({tag, ".job_cycles"}, bus.job_cycles,        32'd0);
    endtask

    int n_r, d_r, l_r;

    initial begin
        rst           = 1'b0;
        bus.start     = 1'b0;
        bus.abort     = 1'b0;
        bus.num_tiles = 8'd0;
        repeat (3) @(negedge clk);
        check_reset_vals("reset");
        rst = 1'b1;
        @(negedge clk);

        // Zero-tile job: done two cycles after start, one busy cycle.
        clear_mon();
        start_job(0);
        check("zero.done_early", {31'd0, bus.done}, 32'd0);
        check("zero.busy_early", {31'd0, bus.busy}, 32'd1);
        @(negedge clk);
        check("zero.done", {31'd0, bus.done}, 32'd1);
        check("zero.busy", {31'd0, bus.busy}, 32'd0);
        check("zero.job_cycles", bus.job_cycles, 32'd1);
        @(negedge clk);
        check("zero.done_once", {31'd0, bus.done}, 32'd0);
        check("zero.falls", falls, 0);

        // Three-tile job with a long result window.
        run_ok(3, 84, 1024, "three");

        // Engine never responds: timeout.
        clear_mon();
        eng_never = 1'b1;
        start_job(2);
        wait_idle(TMO + 50, "tmo");
        check("tmo.err_after_release", err_cyc - fall_cyc, TMO);
        check("tmo.error", {31'd0, bus.error}, 32'd1);
        check("tmo.eng_idle_in_err", {31'd0, err_idle}, 32'd1);
        check("tmo.eng_idle", {31'd0, bus.eng_idle}, 32'd1);
        check("tmo.dones", dones, 0);
        check("tmo.falls", falls, 1);
        eng_never = 1'b0;

        // Rise exactly on the timeout cycle, plus an ignored second start.
        clear_mon();
        eng_delay = TMO;
        eng_len   = 1;
        start_job(1);
        repeat (10) @(negedge clk);
        bus.num_tiles = 8'd7;
        bus.start     = 1'b1;
        @(negedge clk);
        bus.start     = 1'b0;
        wait_idle(job_len(1, TMO, 1) + 20, "edge_tmo");
        check("edge_tmo.error", {31'd0, bus.error}, 32'd0);
        check("edge_tmo.dones", dones, 1);
        check("edge_tmo.falls", falls, 1);
        check("edge_tmo.tile_idx", {24'd0, bus.tile_idx}, 32'd0);
        check("edge_tmo.job_cycles", bus.job_cycles, job_len(1, TMO, 1));

        // Abort during tile 1 of 4.
        clear_mon();
        eng_delay = 20;
        eng_len   = 30;
        start_job(4);
        wait_tile_run(8'd1, 400, "abort");
        bus.abort = 1'b1;
        @(negedge clk);
        bus.abort = 1'b0;
        check("abort.eng_idle", {31'd0, bus.eng_idle}, 32'd1);
        check("abort.busy", {31'd0, bus.busy}, 32'd0);
        check("abort.tile_idx", {24'd0, bus.tile_idx}, 32'd1);
        check("abort.done0", {31'd0, bus.done}, 32'd0);
        @(negedge clk);
        check("abort.done1", {31'd0, bus.done}, 32'd0);
        check("abort.error", {31'd0, bus.error}, 32'd0);

        // Reset in the drain phase of tile 2, then a clean job.
        clear_mon();
        eng_delay = 10;
        eng_len   = 50;
        start_job(4);
        wait_tile_run(8'd2, 600, "rst_mid");
        repeat (15) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        check_reset_vals("rst_mid");
        rst = 1'b1;
        @(negedge clk);
        run_ok(2, 10, 50, "after_rst");

        // Randomized jobs against the timing reference.
        for (int j = 0; j < 4; j++) begin
            n_r = int'($urandom_range(4, 1));
            d_r = int'($urandom_range(150, 1));
            l_r = int'($urandom_range(150, 1));
            run_ok(n_r, d_r, l_r, "rand");
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/spmv_tile_sched.md
SPMV_TILE_SCHED -- requirements
Module: spmv_tile_sched

Interface
REQ-001 Parameter IN_STRIDE, default 64: input-vector words per tile; in_base step.
REQ-002 Parameter OUT_STRIDE, default 1024: result words per tile; out_base step.
REQ-003 Parameter TIMEOUT, default 2048: max cycles from engine release to dateout falling edge.
REQ-004 Parameter ARM_CYCLES, default 2: cycles engine_idle is held high before each tile.
REQ-005 clk  in  1  clock; all logic on rising edge.
REQ-006 rst  in  1  reset, synchronous, active-low.
REQ-007 start  in  1  job request pulse; sampled only in S_IDLE.
REQ-008 abort  in  1  job cancel pulse; honoured in any state except S_IDLE.
REQ-009 num_tiles  in  8  tile count, latched on accepted start.
REQ-010 eng_dateout  in  1  engine result-valid window, high while results stream.
REQ-011 eng_idle  out  1  engine hold/restart; high parks engine, falling edge launches one tile.
REQ-012 busy  out  1  high from accepted start until done or error.
REQ-013 done  out  1  one-cycle pulse at job completion.
REQ-014 error  out  1  sticky timeout flag; cleared by accepted start or reset.
REQ-015 tile_idx  out  8  index of current tile.
REQ-016 in_base  out  16  tile_idx*IN_STRIDE, low 16 bits kept.
REQ-017 out_base  out  16  tile_idx*OUT_STRIDE, low 16 bits kept.
REQ-018 job_cycles  out  32  cycles busy in last/current job, saturating at all-ones.

Function
REQ-019 States: S_IDLE, S_ARM, S_RUN, S_DRAIN, S_NEXT, S_DONE, S_ERR.
REQ-020 S_IDLE: eng_idle=1; start=1 -> latch num_tiles, tile_idx=0, clear error and job_cycles, busy=1; num_tiles=0 -> S_DONE, else S_ARM.
REQ-021 S_ARM: eng_idle=1 for exactly ARM_CYCLES cycles, then S_RUN with eng_idle=0 in the first S_RUN cycle.
REQ-022 S_RUN: eng_idle=0; wait for eng_dateout rising edge (1 now, 0 previous cycle) -> S_DRAIN.
REQ-023 S_DRAIN: eng_idle=0; eng_dateout falling edge -> S_NEXT.
REQ-024 S_NEXT (1 cycle): eng_idle=1; tile_idx+1 == num_tiles -> S_DONE, else tile_idx increments and -> S_ARM.
REQ-025 S_DONE (1 cycle): done=1, busy=0 next cycle, -> S_IDLE; tile_idx holds last value.
REQ-026 in_base/out_base are registered and update in the same cycle as tile_idx.
REQ-027 Watchdog counts cycles in S_RUN+S_DRAIN, cleared on S_ARM entry; value reaching TIMEOUT -> S_ERR.
REQ-028 S_ERR (1 cycle): eng_idle=1, error=1, busy=0 next cycle, no done pulse, -> S_IDLE.
REQ-029 Edge detected and timeout on the same cycle: edge wins, watchdog ignored that cycle.
REQ-030 abort=1 in S_ARM..S_DONE: -> S_IDLE next cycle, eng_idle=1, busy=0, no done, error unchanged; abort and start together in S_IDLE: start taken, abort ignored.
REQ-031 start outside S_IDLE is ignored; num_tiles changes after latch have no effect.
REQ-032 job_cycles increments every cycle busy=1.

Reset
REQ-033 rst=0 at any clock, including mid-tile: state=S_IDLE, eng_idle=1, busy=0, done=0, error=0, tile_idx=0, in_base=0, out_base=0, job_cycles=0, watchdog=0, dateout history=0.

Structure
REQ-034 State encodings and default stride/timeout constants go in shared package spmv_pkg.
REQ-035 Single sub-module spmv_watchdog (load/clear, count enable, expire flag); the rest stays flat.

Verification
REQ-036 num_tiles=3, engine model raises dateout 84 cycles after release for 1024 cycles -> three eng_idle falling edges, out_base 0/1024/2048, one done pulse, error=0.
REQ-037 num_tiles=0 -> done two cycles after start, eng_idle never low, job_cycles=1.
REQ-038 Engine never raises dateout, TIMEOUT=2048 -> S_ERR 2048 cycles after release, error=1, eng_idle=1, no done.
REQ-039 abort during tile 1 of 4 -> S_IDLE next cycle, eng_idle=1, busy=0, no done, tile_idx=1.
REQ-040 rst=0 pulse mid-S_DRAIN of tile 2 -> all outputs at reset values next cycle; new start runs cleanly from tile 0.
REQ-041 dateout rises on exactly cycle TIMEOUT -> S_DRAIN, error=0; second start while busy -> ignored, num_tiles unchanged.
